// File: rtl/bomb_pkg.sv
// ============================================================================
//  Module      : bomb_pkg
//  Description : Shared definitions for the bomb datapath: grid geometry
//                defaults (also used by the placement latch and the player
//                stage), the fuse-controller state encoding and a small
//                helper for sizing the shared phase counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bomb_pkg;

    // Grid geometry defaults
    localparam int c_COORD_W  = 6;
    localparam int c_GRID_MAX = 63;

    // Fuse controller state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ARMED    = 2'd1;
    localparam logic [1:0] c_ST_EXPLODE  = 2'd2;
    localparam logic [1:0] c_ST_COOLDOWN = 2'd3;

    // Largest of three phase lengths; sizes the shared tick counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : bomb_pkg

`default_nettype wire

// File: rtl/blast_hit_calc.sv
// ============================================================================
//  Module      : blast_hit_calc
//  Description : Combinational cross-membership test. Reports whether the
//                query cell lies on the horizontal or vertical arm of a blast
//                centred at (center_x, center_y) with the given arm length,
//                and inside the playing grid. Distances are taken in one
//                extra signed bit, so there is no modular wrap at the border.
//                Shared with the VGA renderer; callers register the result.
//  Ports       : center_x/center_y  in  blast centre cell
//                radius             in  current arm length in cells
//                query_x/query_y    in  cell under test
//                hit                out query cell is covered by the cross
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blast_hit_calc
    import bomb_pkg::*;
#(
    parameter int COORD_W  = c_COORD_W,
    parameter int GRID_MAX = c_GRID_MAX,
    parameter int RAD_W    = 2
) (
    input  logic [COORD_W-1:0] center_x,
    input  logic [COORD_W-1:0] center_y,
    input  logic [RAD_W-1:0]   radius,
    input  logic [COORD_W-1:0] query_x,
    input  logic [COORD_W-1:0] query_y,
    output logic               hit
);

    // Grid limit held one bit wider than the coordinates so the bound check
    // stays a real comparison even when GRID_MAX is the largest coordinate.
    localparam logic [COORD_W:0] c_GRID_LIM = (COORD_W+1)'(GRID_MAX);

    logic signed [COORD_W:0] w_dx;
    logic signed [COORD_W:0] w_dy;
    logic        [COORD_W:0] w_abs_dx;
    logic        [COORD_W:0] w_abs_dy;
    logic        [COORD_W:0] w_rad_ext;
    logic                    w_in_grid;
    logic                    w_on_vert;
    logic                    w_on_horz;

    assign w_dx = $signed({1'b0, query_x}) - $signed({1'b0, center_x});
    assign w_dy = $signed({1'b0, query_y}) - $signed({1'b0, center_y});

    // Coordinate differences span -GRID_MAX..GRID_MAX, so negation never
    // overflows the extended width.
    assign w_abs_dx = w_dx[COORD_W] ? (~w_dx + 1'b1) : w_dx;
    assign w_abs_dy = w_dy[COORD_W] ? (~w_dy + 1'b1) : w_dy;

    assign w_rad_ext = {{(COORD_W+1-RAD_W){1'b0}}, radius};

    assign w_in_grid = ({1'b0, query_x} <= c_GRID_LIM) &&
                       ({1'b0, query_y} <= c_GRID_LIM);

    assign w_on_vert = (query_x == center_x) && (w_abs_dy <= w_rad_ext);
    assign w_on_horz = (query_y == center_y) && (w_abs_dx <= w_rad_ext);

    assign hit = w_in_grid && (w_on_vert || w_on_horz);

endmodule : blast_hit_calc

`default_nettype wire

// File: rtl/bomb_fuse_ctrl.sv
// ============================================================================
//  Module      : bomb_fuse_ctrl
//  Description : Bomb lifecycle controller. Latches the dropped bomb cell,
//                then runs fuse, blast and cooldown phases counted in
//                game-frame ticks. During the blast the cross grows by one
//                cell per tick up to BLAST_RADIUS. A registered per-cell hit
//                test serves the player-collision and VGA draw stages.
//  Ports       : clk, reset (async, active high), tick (frame strobe)
//                bomb_dropped, bomb_x, bomb_y      drop request and cell
//                query_x, query_y                  cell tested against blast
//                drop_accepted, detonate           one-cycle pulses
//                armed, exploding                  phase flags
//                center_x, center_y, radius        latched cell, arm length
//                blast_hit                         query hit, 1-cycle latency
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_fuse_ctrl
    import bomb_pkg::*;
#(
    parameter int COORD_W        = c_COORD_W,
    parameter int GRID_MAX       = c_GRID_MAX,
    parameter int FUSE_TICKS     = 90,
    parameter int BLAST_TICKS    = 30,
    parameter int BLAST_RADIUS   = 3,
    parameter int COOLDOWN_TICKS = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic                              bomb_dropped,
    input  logic [COORD_W-1:0]                bomb_x,
    input  logic [COORD_W-1:0]                bomb_y,
    input  logic [COORD_W-1:0]                query_x,
    input  logic [COORD_W-1:0]                query_y,
    output logic                              drop_accepted,
    output logic                              armed,
    output logic                              exploding,
    output logic                              detonate,
    output logic [COORD_W-1:0]                center_x,
    output logic [COORD_W-1:0]                center_y,
    output logic [$clog2(BLAST_RADIUS+1)-1:0] radius,
    output logic                              blast_hit
);

    localparam int c_RAD_W     = $clog2(BLAST_RADIUS + 1);
    localparam int c_MAX_TICKS = max3(FUSE_TICKS, BLAST_TICKS, COOLDOWN_TICKS);
    localparam int c_CNT_W     = $clog2(c_MAX_TICKS + 1);

    localparam logic [c_CNT_W-1:0] c_FUSE_LAST  = c_CNT_W'(FUSE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_BLAST_LAST = c_CNT_W'(BLAST_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_COOL_LAST  = c_CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [c_RAD_W-1:0] c_RAD_MAX    = c_RAD_W'(BLAST_RADIUS);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_RAD_W-1:0] r_radius;
    logic [COORD_W-1:0] r_center_x;
    logic [COORD_W-1:0] r_center_y;
    logic               r_drop_accepted;
    logic               r_detonate;
    logic               r_armed;
    logic               r_exploding;
    logic               r_blast_hit;
    logic               w_cross_hit;

    // ------------------------------------------------------------------
    // Lifecycle FSM with shared phase counter, radius and centre latch.
    // armed/exploding are decoded from the next state so they change on
    // the same edge as the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_cnt           <= '0;
            r_radius        <= '0;
            r_center_x      <= '0;
            r_center_y      <= '0;
            r_drop_accepted <= 1'b0;
            r_detonate      <= 1'b0;
            r_armed         <= 1'b0;
            r_exploding     <= 1'b0;
        end else begin
            r_drop_accepted <= 1'b0;
            r_detonate      <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A tick coinciding with the drop is deliberately not
                    // counted: the fuse starts from zero on the next edge.
                    if (bomb_dropped) begin
                        r_center_x      <= bomb_x;
                        r_center_y      <= bomb_y;
                        r_drop_accepted <= 1'b1;
                        r_cnt           <= '0;
                        r_state         <= c_ST_ARMED;
                        r_armed         <= 1'b1;
                    end
                end
                c_ST_ARMED: begin
                    if (tick) begin
                        if (r_cnt == c_FUSE_LAST) begin
                            r_cnt       <= '0;
                            r_radius    <= '0;
                            r_detonate  <= 1'b1;
                            r_state     <= c_ST_EXPLODE;
                            r_armed     <= 1'b0;
                            r_exploding <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_EXPLODE: begin
                    if (tick) begin
                        if (r_cnt == c_BLAST_LAST) begin
                            r_cnt       <= '0;
                            r_radius    <= '0;
                            r_state     <= c_ST_COOLDOWN;
                            r_exploding <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_radius < c_RAD_MAX) begin
                                r_radius <= r_radius + 1'b1;
                            end
                        end
                    end
                end
                c_ST_COOLDOWN: begin
                    if (tick) begin
                        if (r_cnt == c_COOL_LAST) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt       <= '0;
                    r_radius    <= '0;
                    r_state     <= c_ST_IDLE;
                    r_armed     <= 1'b0;
                    r_exploding <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hit test: geometry from the shared calculator, gated by the blast
    // phase and registered for a fixed one-cycle query latency.
    // ------------------------------------------------------------------
    blast_hit_calc #(
        .COORD_W  (COORD_W),
        .GRID_MAX (GRID_MAX),
        .RAD_W    (c_RAD_W)
    ) u_blast_hit_calc (
        .center_x (r_center_x),
        .center_y (r_center_y),
        .radius   (r_radius),
        .query_x  (query_x),
        .query_y  (query_y),
        .hit      (w_cross_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blast_hit <= 1'b0;
        end else begin
            r_blast_hit <= r_exploding && w_cross_hit;
        end
    end

    assign drop_accepted = r_drop_accepted;
    assign detonate      = r_detonate;
    assign armed         = r_armed;
    assign exploding     = r_exploding;
    assign center_x      = r_center_x;
    assign center_y      = r_center_y;
    assign radius        = r_radius;
    assign blast_hit     = r_blast_hit;

endmodule : bomb_fuse_ctrl

`default_nettype wire

// File: tb/tb_bomb_fuse_ctrl.sv
// ============================================================================
//  Module      : tb_bomb_fuse_ctrl
//  Description : Self-checking bench for bomb_fuse_ctrl. A reference model
//                tracks the bomb by ticks elapsed since drop acceptance and
//                derives phase, radius and cross membership arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bomb_fuse_ctrl;

    localparam int c_F  = 4;
    localparam int c_B  = 8;
    localparam int c_R  = 3;
    localparam int c_C  = 3;
    localparam int c_CW = 6;
    localparam int c_GM = 63;
    localparam int c_RW = $clog2(c_R + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tick = 1'b0;
    logic            bomb_dropped = 1'b0;
    logic [c_CW-1:0] bomb_x = '0;
    logic [c_CW-1:0] bomb_y = '0;
    logic [c_CW-1:0] query_x = '0;
    logic [c_CW-1:0] query_y = '0;
    logic            drop_accepted;
    logic            armed;
    logic            exploding;
    logic            detonate;
    logic [c_CW-1:0] center_x;
    logic [c_CW-1:0] center_y;
    logic [c_RW-1:0] radius;
    logic            blast_hit;

    bomb_fuse_ctrl #(
        .COORD_W        (c_CW),
        .GRID_MAX       (c_GM),
        .FUSE_TICKS     (c_F),
        .BLAST_TICKS    (c_B),
        .BLAST_RADIUS   (c_R),
        .COOLDOWN_TICKS (c_C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .bomb_dropped  (bomb_dropped),
        .bomb_x        (bomb_x),
        .bomb_y        (bomb_y),
        .query_x       (query_x),
        .query_y       (query_y),
        .drop_accepted (drop_accepted),
        .armed         (armed),
        .exploding     (exploding),
        .detonate      (detonate),
        .center_x      (center_x),
        .center_y      (center_y),
        .radius        (radius),
        .blast_hit     (blast_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a bomb is either absent or has seen m_t ticks since
    // its drop was accepted; everything else follows from m_t.
    bit m_busy = 1'b0;
    int m_t    = 0;
    int m_cx   = 0;
    int m_cy   = 0;

    function automatic bit m_expl(input bit busy, input int t);
        return busy && (t >= c_F) && (t < c_F + c_B);
    endfunction

    function automatic int m_rad(input bit busy, input int t);
        if (!m_expl(busy, t)) return 0;
        return ((t - c_F) < c_R) ? (t - c_F) : c_R;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit m_hit(input bit busy, input int t, input int cx,
                                 input int cy, input int qx, input int qy);
        int r;
        if (!m_expl(busy, t)) return 1'b0;
        if (qx > c_GM || qy > c_GM) return 1'b0;
        r = m_rad(busy, t);
        return ((qx == cx) && (iabs(qy - cy) <= r)) ||
               ((qy == cy) && (iabs(qx - cx) <= r));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; model advanced on the edge, outputs checked #1 later.
    task automatic step(input bit drop, input int bx, input int by,
                        input bit tk, input int qx, input int qy);
        bit exp_hit;
        bit exp_acc;
        bit exp_det;
        bomb_dropped = drop;
        bomb_x       = c_CW'(bx);
        bomb_y       = c_CW'(by);
        tick         = tk;
        query_x      = c_CW'(qx);
        query_y      = c_CW'(qy);
        @(posedge clk);
        exp_hit = m_hit(m_busy, m_t, m_cx, m_cy, qx, qy);
        exp_acc = 1'b0;
        exp_det = 1'b0;
        if (!m_busy) begin
            if (drop) begin
                m_busy  = 1'b1;
                m_t     = 0;
                m_cx    = bx;
                m_cy    = by;
                exp_acc = 1'b1;
            end
        end else if (tk) begin
            m_t++;
            if (m_t == c_F) exp_det = 1'b1;
            if (m_t == c_F + c_B + c_C) m_busy = 1'b0;
        end
        #1;
        check("drop_accepted", int'(drop_accepted), int'(exp_acc));
        check("detonate",      int'(detonate),      int'(exp_det));
        check("armed",         int'(armed),         int'(m_busy && m_t < c_F));
        check("exploding",     int'(exploding),     int'(m_expl(m_busy, m_t)));
        check("radius",        int'(radius),        m_rad(m_busy, m_t));
        check("center_x",      int'(center_x),      m_cx);
        check("center_y",      int'(center_y),      m_cy);
        check("blast_hit",     int'(blast_hit),     int'(exp_hit));
    endtask

    // Run the current bomb back to idle, optionally hammering drop requests.
    task automatic drain(input bit spam_drops);
        for (int n = 0; n < 200 && m_busy; n++) begin
            step(spam_drops, $urandom_range(0, c_GM), $urandom_range(0, c_GM),
                 1'b1, 0, 0);
        end
        check("drain_bound", int'(m_busy), 0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b1, m_cx, m_cy);
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_armed",     int'(armed), 0);
        check("rst_exploding", int'(exploding), 0);
        check("rst_center_x",  int'(center_x), 0);
        check("rst_blast_hit", int'(blast_hit), 0);
        reset = 1'b0;

        // ---------------- fuse timing, tick every 3 clk ----------------
        step(1'b1, 10, 12, 1'b0, 0, 0);
        for (int i = 0; i < 3 * (c_F + c_B + c_C) + 3 && m_busy; i++) begin
            step(1'b0, 0, 0, (i % 3) == 2, 10, 13);
        end
        drain(1'b0);

        // ---------------- cross shape around (10,12), radius 2 ----------------
        step(1'b1, 10, 12, 1'b0, 0, 0);
        ticks(c_F + 2);
        step(1'b0, 0, 0, 1'b0, 10, 14); check("q10_14", int'(blast_hit), 1);
        step(1'b0, 0, 0, 1'b0, 8, 12);  check("q8_12",  int'(blast_hit), 1);
        step(1'b0, 0, 0, 1'b0, 11, 13); check("q11_13", int'(blast_hit), 0);
        step(1'b0, 0, 0, 1'b0, 10, 15); check("q10_15", int'(blast_hit), 0);
        // Drops mid-lifecycle are ignored and leave the centre intact.
        drain(1'b1);

        // ---------------- no wrap at the grid border ----------------
        step(1'b1, 0, 0, 1'b0, 0, 0);
        ticks(c_F + 3);
        step(1'b0, 0, 0, 1'b0, 63, 0); check("q63_0", int'(blast_hit), 0);
        step(1'b0, 0, 0, 1'b0, 3, 0);  check("q3_0",  int'(blast_hit), 1);
        step(1'b0, 0, 0, 1'b0, 0, 63); check("q0_63", int'(blast_hit), 0);
        drain(1'b1);
        step(1'b1, 33, 44, 1'b0, 0, 0);
        check("accept_after_idle", int'(drop_accepted), 1);
        drain(1'b0);

        // ---------------- drop and tick together in idle ----------------
        step(1'b1, 5, 6, 1'b1, 0, 0);
        ticks(c_F - 1);
        check("not_yet_exploding", int'(exploding), 0);
        ticks(1);
        check("detonate_after_f", int'(detonate), 1);

        // ---------------- async reset mid-blast (cnt 5, radius 3) ----------------
        ticks(5);
        check("pre_reset_radius", int'(radius), 3);
        #2 reset = 1'b1;
        #1;
        check("async_armed",     int'(armed), 0);
        check("async_exploding", int'(exploding), 0);
        check("async_radius",    int'(radius), 0);
        check("async_center_y",  int'(center_y), 0);
        check("async_blast_hit", int'(blast_hit), 0);
        @(negedge clk);
        reset  = 1'b0;
        m_busy = 1'b0;
        m_t    = 0;
        m_cx   = 0;
        m_cy   = 0;
        step(1'b1, 21, 22, 1'b0, 0, 0);
        check("accept_after_reset", int'(drop_accepted), 1);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 600; i++) begin
            int bx, by, qx, qy;
            bx = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? c_GM : 0)
                                             : int'($urandom_range(0, c_GM));
            by = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? c_GM : 0)
                                             : int'($urandom_range(0, c_GM));
            qx = (m_cx + int'($urandom_range(0, 10)) - 5 + 64) % 64;
            qy = (m_cy + int'($urandom_range(0, 10)) - 5 + 64) % 64;
            case ($urandom_range(0, 2))
                0: qx = m_cx;
                1: qy = m_cy;
                default: ;
            endcase
            step($urandom_range(0, 9) < 3, bx, by, $urandom_range(0, 9) < 5, qx, qy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bomb_fuse_ctrl

`default_nettype wire
